// File: rtl/apu_pkg.sv
// Types and defaults shared between the pulse sequencer and the pulse channel.
package apu_pkg;
  localparam int SEQ_DEPTH    = 16;
  localparam int SEQ_TICK_DIV = 256;
  localparam int SEQ_LEN_W    = 8;

  typedef logic [10:0] period_t;
  typedef logic [1:0]  duty_t;

  typedef struct packed {
    logic [SEQ_LEN_W-1:0] length;
    duty_t                duty;
    period_t              period;
  } seq_entry_t;

  typedef enum logic [1:0] {IDLE, FETCH, SEND, HOLD} seq_state_t;
endpackage

// File: rtl/apu_seq_mem.sv
// Note table: synchronous write, registered read, cleared by reset.
module apu_seq_mem #(
  parameter int DEPTH  = 16,
  parameter int W      = 21,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [W-1:0]      i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [W-1:0]      o_rd_data
);
  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [W-1:0]            r_rd_data;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mem     <= '0;
      r_rd_data <= '0;
    end else begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/apu_pulse_seq.sv
// Walks the note table, issuing period/duty transactions and holding each note
// for length x TICK_DIV clocks.
module apu_pulse_seq
  import apu_pkg::*;
#(
  parameter int DEPTH    = SEQ_DEPTH,
  parameter int TICK_DIV = SEQ_TICK_DIV,
  parameter int LEN_W    = SEQ_LEN_W,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int PRE_W    = $clog2(TICK_DIV)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [LEN_W+12:0] i_wr_data,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_loop,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_cur_idx,
  output period_t           o_period_s,
  output logic              o_period_s_vld,
  input  logic              i_period_s_rdy,
  output duty_t             o_duty_s,
  output logic              o_duty_s_vld,
  input  logic              i_duty_s_rdy
);
  seq_state_t        r_state, w_state_n;
  logic [ADDR_W-1:0] r_idx, w_idx_n;
  logic              r_pvld, w_pvld_n, r_dvld, w_dvld_n;
  period_t           r_per, w_per_n;
  duty_t             r_duty, w_duty_n;
  logic [PRE_W-1:0]  r_pre, w_pre_n;
  logic [LEN_W-1:0]  r_len, w_len_n;
  logic              r_pend, w_pend_n;
  logic [LEN_W+12:0] w_ent;
  logic [LEN_W-1:0]  w_ent_len;
  logic              w_last;

  // Read address is the next index, so the entry is ready in the FETCH cycle.
  apu_seq_mem #(.DEPTH(DEPTH), .W(LEN_W+13), .ADDR_W(ADDR_W)) u_mem (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_wr_en  (i_wr_en),
    .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data),
    .i_rd_addr(w_idx_n),
    .o_rd_data(w_ent)
  );

  assign w_ent_len = w_ent[LEN_W+12:13];
  assign w_last    = (r_idx == ADDR_W'(DEPTH-1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_pvld  <= 1'b0;
      r_dvld  <= 1'b0;
      r_per   <= '0;
      r_duty  <= '0;
      r_pre   <= '0;
      r_len   <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_pvld  <= w_pvld_n;
      r_dvld  <= w_dvld_n;
      r_per   <= w_per_n;
      r_duty  <= w_duty_n;
      r_pre   <= w_pre_n;
      r_len   <= w_len_n;
      r_pend  <= w_pend_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_pvld_n  = r_pvld;
    w_dvld_n  = r_dvld;
    w_per_n   = r_per;
    w_duty_n  = r_duty;
    w_pre_n   = r_pre;
    w_len_n   = r_len;
    w_pend_n  = r_pend;
    case (r_state)
      IDLE: begin
        if (i_start && !i_stop) begin
          w_state_n = FETCH;
          w_idx_n   = '0;
        end
      end
      FETCH: begin
        if (i_stop) begin
          w_state_n = IDLE;
        end else if (w_ent_len == '0) begin
          // End marker: loop back unless we are already at the head.
          if (i_loop && r_idx != '0) w_idx_n = '0;
          else                       w_state_n = IDLE;
        end else begin
          w_state_n = SEND;
          w_pvld_n  = 1'b1;
          w_dvld_n  = 1'b1;
          w_per_n   = w_ent[10:0];
          w_duty_n  = w_ent[12:11];
          w_len_n   = w_ent_len;
          w_pre_n   = '0;
        end
      end
      SEND: begin
        w_pvld_n = r_pvld & ~i_period_s_rdy;
        w_dvld_n = r_dvld & ~i_duty_s_rdy;
        w_pend_n = r_pend | i_stop;
        if (!w_pvld_n && !w_dvld_n) begin
          w_state_n = w_pend_n ? IDLE : HOLD;
          w_pend_n  = 1'b0;
        end
      end
      HOLD: begin
        if (i_stop) begin
          w_state_n = IDLE;
        end else if (r_pre == PRE_W'(TICK_DIV-1)) begin
          w_pre_n = '0;
          w_len_n = r_len - LEN_W'(1);
          if (r_len == LEN_W'(1)) begin
            if (w_last) begin
              w_state_n = i_loop ? FETCH : IDLE;
              if (i_loop) w_idx_n = '0;
            end else begin
              w_state_n = FETCH;
              w_idx_n   = r_idx + ADDR_W'(1);
            end
          end
        end else begin
          w_pre_n = r_pre + PRE_W'(1);
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign o_busy         = (r_state != IDLE);
  assign o_cur_idx      = r_idx;
  assign o_period_s     = r_per;
  assign o_period_s_vld = r_pvld;
  assign o_duty_s       = r_duty;
  assign o_duty_s_vld   = r_dvld;
endmodule

// File: tb/tb_apu_pulse_seq.sv
// Scoreboard bench for apu_pulse_seq: a table-walk model predicts transactions
// and the clocks between a note's completion and the next visible event.
module tb_apu_pulse_seq;
  import apu_pkg::*;
  localparam int DEPTH = 16, TD = 4, LEN_W = 8, AW = 4;

  logic clk = 0, rst = 0, wr_en = 0, start = 0, stop = 0, loop = 0;
  logic prdy = 0, drdy = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [LEN_W+12:0] wr_data = '0;
  logic busy, pvld, dvld;
  logic [AW-1:0] cur_idx;
  period_t per;
  duty_t duty;

  always #5 clk = ~clk;

  apu_pulse_seq #(.DEPTH(DEPTH), .TICK_DIV(TD), .LEN_W(LEN_W)) dut (
    .i_clk(clk), .i_reset(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_start(start), .i_stop(stop), .i_loop(loop), .o_busy(busy), .o_cur_idx(cur_idx),
    .o_period_s(per), .o_period_s_vld(pvld), .i_period_s_rdy(prdy),
    .o_duty_s(duty), .o_duty_s_vld(dvld), .i_duty_s_rdy(drdy));

  typedef struct {int idx; int per; int duty;} exp_t;
  exp_t qp[$], qd[$];
  int   qg[$];
  int   tlen[DEPTH], tduty[DEPTH], tper[DEPTH];
  int   n_chk = 0, n_fail = 0, hs_cnt = 0;
  bit   rnd_rdy = 1, pforce = 0, dforce = 0, gap_en = 1;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: walk the table; gap = clocks from note completion to next vld or busy low.
  function automatic void build(int n_max, bit lp);
    int idx = 0, n = 0, g, nxt;
    exp_t e;
    if (tlen[0] == 0) return;
    while (1) begin
      e.idx = idx; e.per = tper[idx]; e.duty = tduty[idx];
      qp.push_back(e); qd.push_back(e); n++;
      g = tlen[idx] * TD + 1;
      if (idx == DEPTH - 1 && !lp) begin qg.push_back(g); return; end
      nxt = (idx == DEPTH - 1) ? 0 : idx + 1;
      g++;
      if (tlen[nxt] == 0) begin
        if (lp && nxt != 0) begin nxt = 0; g++; end
        else begin qg.push_back(g); return; end
      end
      qg.push_back(g);
      if (n >= n_max) return;
      idx = nxt;
    end
  endfunction

  task automatic flush();
    qp.delete(); qd.delete(); qg.delete();
  endtask

  task automatic rand_table(bit with_zeros);
    for (int i = 0; i < DEPTH; i++) begin
      tper[i]  = $urandom_range(0, 2047);
      tduty[i] = $urandom_range(0, 3);
      tlen[i]  = (with_zeros && $urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 3);
    end
    tlen[0] = $urandom_range(1, 3);
  endtask

  task automatic load_table();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      wr_en = 1; wr_addr = AW'(i);
      wr_data = {LEN_W'(tlen[i]), 2'(tduty[i]), 11'(tper[i])};
    end
    @(negedge clk); wr_en = 0;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  task automatic wait_idle(string nm);
    int c = 0;
    while (busy && c < 5000) begin @(negedge clk); c++; end
    chk(nm, busy, 0);
  endtask

  task automatic finish_round(string nm);
    wait_idle({nm, "_idle"});
    repeat (2) @(negedge clk);
    chk({nm, "_drained"}, qp.size() + qd.size() + qg.size(), 0);
  endtask

  task automatic run_loop(string nm);
    int c = 0;
    loop = 1; build(40, 1); do_start();
    while (qp.size() > 8 && c < 5000) begin @(negedge clk); c++; end
    chk({nm, "_progress"}, qp.size() > 8, 0);
    gap_en = 0; stop = 1;
    @(negedge clk); stop = 0;
    wait_idle({nm, "_stop_idle"});
    @(negedge clk); flush(); loop = 0;
    @(negedge clk); gap_en = 1;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_rdy) begin
        prdy = ($urandom_range(0, 3) != 0);
        drdy = ($urandom_range(0, 3) != 0);
      end else begin
        prdy = pforce; drdy = dforce;
      end
    end
  end

  initial begin
    bit pp = 0, pd = 0, gact = 0;
    int lper = 0, lduty = 0, gcnt = 0, gexp = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!gap_en) gact = 0;
      if (rst) begin
        pp = 0; pd = 0; gact = 0;
      end else begin
        if (pp) begin chk("p_hold_vld", pvld, 1); chk("p_hold_pay", per, lper); end
        if (pd) begin chk("d_hold_vld", dvld, 1); chk("d_hold_pay", duty, lduty); end
        if (gact) begin
          gcnt++;
          if (pvld || dvld || !busy) begin chk("hold_gap", gcnt, gexp); gact = 0; end
          else if (gcnt > 3000) begin chk("hold_gap_timeout", gcnt, gexp); gact = 0; end
        end
        if (pvld && prdy) begin
          hs_cnt++;
          if (qp.size() == 0) chk("p_unexpected", per, -1);
          else begin e = qp.pop_front(); chk("p_payload", per, e.per); chk("p_idx", cur_idx, e.idx); end
        end
        if (dvld && drdy) begin
          hs_cnt++;
          if (qd.size() == 0) chk("d_unexpected", duty, -1);
          else begin e = qd.pop_front(); chk("d_payload", duty, e.duty); chk("d_idx", cur_idx, e.idx); end
        end
        if (gap_en && ((pvld && prdy) || (dvld && drdy)) && !(pvld && !prdy) && !(dvld && !drdy)
            && qg.size() > 0) begin
          gexp = qg.pop_front(); gact = 1; gcnt = 0;
        end
        pp = pvld && !prdy; lper = per;
        pd = dvld && !drdy; lduty = duty;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int c, h0;
    #1 rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_pvld", pvld, 0); chk("rst_dvld", dvld, 0);
    chk("rst_idx", cur_idx, 0); chk("rst_per", per, 0);
    rst = 0;

    // Single note with start latency
    for (int i = 0; i < DEPTH; i++) begin tlen[i] = 0; tduty[i] = 0; tper[i] = 0; end
    tlen[0] = 2; tduty[0] = 1; tper[0] = 'h1FD;
    load_table();
    rnd_rdy = 0; pforce = 1; dforce = 1;
    build(16, 0); do_start();
    chk("lat_fetch_busy", busy, 1); chk("lat_fetch_vld", pvld, 0);
    @(negedge clk);
    chk("lat_send_pvld", pvld, 1); chk("lat_send_dvld", dvld, 1);
    finish_round("single");

    // Period backpressure
    rand_table(0); tlen[1] = 0; load_table();
    pforce = 0; dforce = 1;
    build(16, 0); do_start();
    c = 0;
    while (!pvld && c < 10) begin @(negedge clk); c++; end
    chk("bp_pvld_seen", pvld, 1);
    @(negedge clk);
    chk("bp_dvld_drop", dvld, 0); chk("bp_pvld_held", pvld, 1);
    repeat (3) @(negedge clk);
    pforce = 1;
    finish_round("bp");

    // Loop/wrap with all lengths 1, then random table with an end marker
    rnd_rdy = 1;
    for (int i = 0; i < DEPTH; i++) begin tlen[i] = 1; tper[i] = $urandom_range(0, 2047); tduty[i] = i % 4; end
    load_table();
    run_loop("wrap");
    rand_table(0); tlen[$urandom_range(1, DEPTH - 1)] = 0; load_table();
    run_loop("endloop");

    // Random non-looping tables
    for (int r = 0; r < 4; r++) begin
      rand_table(1); load_table();
      build(16, 0); do_start();
      finish_round("rand");
    end

    // Stop while both channels stalled
    rand_table(0); load_table();
    rnd_rdy = 0; pforce = 0; dforce = 0; gap_en = 0;
    build(16, 0); do_start();
    c = 0;
    while (!pvld && c < 10) begin @(negedge clk); c++; end
    h0 = hs_cnt; stop = 1;
    @(negedge clk); stop = 0;
    repeat (2) @(negedge clk);
    chk("stop_pvld_kept", pvld, 1); chk("stop_dvld_kept", dvld, 1);
    pforce = 1; dforce = 1;
    repeat (2) @(negedge clk);
    chk("stop_busy", busy, 0); chk("stop_pvld", pvld, 0); chk("stop_dvld", dvld, 0);
    chk("stop_txn", hs_cnt - h0, 2);
    flush();
    @(negedge clk); gap_en = 1;

    // Reset during HOLD of entry 1, then end marker at idx0 with loop
    rnd_rdy = 1;
    rand_table(0); tlen[1] = 6; load_table();
    gap_en = 0; h0 = hs_cnt;
    build(16, 0); do_start();
    c = 0;
    while (hs_cnt - h0 < 4 && c < 500) begin @(negedge clk); c++; end
    chk("rh_two_notes", hs_cnt - h0, 4);
    repeat (4) @(negedge clk);
    @(posedge clk); #2 rst = 1;
    #1;
    chk("rh_busy", busy, 0); chk("rh_pvld", pvld, 0); chk("rh_dvld", dvld, 0); chk("rh_idx", cur_idx, 0);
    #10 rst = 0;
    flush();
    for (int i = 0; i < DEPTH; i++) tlen[i] = 0;
    @(negedge clk); gap_en = 1; loop = 1; h0 = hs_cnt;
    build(16, 1); do_start();
    chk("em_fetch_busy", busy, 1);
    @(negedge clk);
    chk("em_idle", busy, 0);
    repeat (5) @(negedge clk);
    chk("em_no_txn", hs_cnt - h0, 0);
    chk("em_still_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
